// File: rtl/led_pkg.sv
// Shared LED pattern definitions: mode encoding, bounce direction values and
// the per-mode starting pattern.
package led_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        FILL   = 2'd3
    } mode_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int MAX_LED = 32;

    // ROT_R starts at the MSB; every other mode starts at the LSB.
    function automatic logic [MAX_LED-1:0] init_pattern(mode_t m, int n_led);
        logic [MAX_LED-1:0] p;
        if (m == ROT_R) p = 32'd1 << (n_led - 1);
        else            p = 32'd1;
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_div.sv
// Step-period divider: free-running up-counter that fires a tick and clears
// whenever it reaches or passes div_max while enabled.
module tick_div #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_max,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // ">=" so that shrinking div_max below cnt fires immediately, never wraps.
    assign tick = en && (cnt >= div_max);

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: steps or reloads a registered LED pattern on each
// divider tick.
//   state (mode_q, dir_q) | meaning
//   ROT_L                 | one-hot rotating toward MSB
//   ROT_R                 | one-hot rotating toward LSB
//   BOUNCE, DIR_UP/DIR_DN | one-hot moving up / down, turning at the ends
//   FILL                  | thermometer fill from LSB, restart after all ones
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_max,
    output logic [N_LED-1:0] led,
    output logic             step_tick
);

    localparam logic [N_LED-1:0] LSB_ONE = {{(N_LED-1){1'b0}}, 1'b1};

    logic             tick;
    mode_t            mode_in;
    mode_t            mode_q, mode_nxt;
    logic             dir_q, dir_nxt;
    logic [N_LED-1:0] led_q, led_nxt;
    logic [MAX_LED-1:0] init_new, init_cur;
    logic             legal;

    tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_max (div_max),
        .tick    (tick)
    );

    assign mode_in  = mode_t'(mode);
    assign init_new = init_pattern(mode_in, N_LED);
    assign init_cur = init_pattern(mode_q, N_LED);

    // A corrupted pattern (zero, or wrong shape for the mode) is repaired at the next tick.
    always_comb begin
        legal = $onehot(led_q);
        if (mode_q == FILL)
            legal = (led_q != '0) && ((led_q & (led_q + LSB_ONE)) == '0);
    end

    always_comb begin
        led_nxt  = led_q;
        dir_nxt  = dir_q;
        mode_nxt = mode_q;
        if (tick) begin
            if (mode_in != mode_q) begin
                mode_nxt = mode_in;
                led_nxt  = init_new[N_LED-1:0];
                dir_nxt  = DIR_UP;
            end else if (!legal) begin
                led_nxt = init_cur[N_LED-1:0];
                dir_nxt = DIR_UP;
            end else begin
                case (mode_q)
                    ROT_L: led_nxt = {led_q[N_LED-2:0], led_q[N_LED-1]};
                    ROT_R: led_nxt = {led_q[0], led_q[N_LED-1:1]};
                    BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (led_q[N_LED-1]) begin
                                led_nxt = led_q >> 1;
                                dir_nxt = DIR_DN;
                            end else begin
                                led_nxt = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_nxt = led_q << 1;
                                dir_nxt = DIR_UP;
                            end else begin
                                led_nxt = led_q >> 1;
                            end
                        end
                    end
                    FILL: begin
                        if (&led_q) led_nxt = LSB_ONE;
                        else        led_nxt = {led_q[N_LED-2:0], 1'b1};
                    end
                    default: led_nxt = LSB_ONE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= LSB_ONE;
            mode_q    <= ROT_L;
            dir_q     <= DIR_UP;
            step_tick <= 1'b0;
        end else begin
            led_q     <= led_nxt;
            mode_q    <= mode_nxt;
            dir_q     <= dir_nxt;
            step_tick <= tick;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized check of led_pattern_gen at N_LED = 8, 2 and 32 against a
// phase-counting reference model.
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] div_max = 24'd3;
    logic [7:0]  led8;
    logic [1:0]  led2;
    logic [31:0] led32;
    logic        st8, st2, st32;

    always #5 clk = ~clk;

    led_pattern_gen #(.N_LED(8), .DIV_W(24)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div_max(div_max),
        .led(led8), .step_tick(st8));
    led_pattern_gen #(.N_LED(2), .DIV_W(24)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div_max(div_max),
        .led(led2), .step_tick(st2));
    led_pattern_gen #(.N_LED(32), .DIV_W(24)) u_dut32 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div_max(div_max),
        .led(led32), .step_tick(st32));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: each instance tracks its mode and a phase within the pattern period.
    int          nl[3] = '{8, 2, 32};
    int          m_mode[3];
    int          m_ph[3];
    int unsigned m_cnt;
    logic        m_step;
    bit          armed = 0;

    function automatic int period(int md, int n);
        return (md == 2) ? 2 * n - 2 : n;
    endfunction

    function automatic logic [31:0] led_of(int md, int p, int n);
        logic [63:0] one;
        one = 64'd1;
        case (md)
            0:       return 32'(one << p);
            1:       return 32'(one << (n - 1 - p));
            2:       return 32'(one << ((p < n) ? p : 2 * n - 2 - p));
            default: return 32'((one << (p + 1)) - 64'd1);
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic [1:0] m, input logic [23:0] d);
        bit t;
        if (r) begin
            m_cnt  = 0;
            m_step = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_mode[k] = 0;
                m_ph[k]   = 0;
            end
        end else if (e) begin
            t      = (m_cnt >= int'(d));
            m_cnt  = t ? 0 : m_cnt + 1;
            m_step = t;
            if (t) begin
                for (int k = 0; k < 3; k++) begin
                    if (int'(m) != m_mode[k]) begin
                        m_mode[k] = int'(m);
                        m_ph[k]   = 0;
                    end else begin
                        m_ph[k] = (m_ph[k] + 1) % period(m_mode[k], nl[k]);
                    end
                end
            end
        end else begin
            m_step = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("led8",  {24'd0, led8}, led_of(m_mode[0], m_ph[0], nl[0]));
        chk("led2",  {30'd0, led2}, led_of(m_mode[1], m_ph[1], nl[1]));
        chk("led32", led32,         led_of(m_mode[2], m_ph[2], nl[2]));
        chk("tick8",  {31'd0, st8},  {31'd0, m_step});
        chk("tick2",  {31'd0, st2},  {31'd0, m_step});
        chk("tick32", {31'd0, st32}, {31'd0, m_step});
        chk("nonzero32", {31'd0, (led32 != 32'd0)}, 32'd1);
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [23:0] d);
        @(negedge clk);
        if (armed) check_outputs();
        rst     = r;
        en      = e;
        mode    = m;
        div_max = d;
        model_edge(r, e, m, d);
        armed = 1;
    endtask

    initial begin
        logic [1:0]  rm;
        logic [23:0] rd;
        logic        re;

        repeat (3) drive(1'b1, 1'b1, 2'd0, 24'd3);
        repeat (40) drive(1'b0, 1'b1, 2'd0, 24'd3);       // ROT_L, step every 4
        repeat (80) drive(1'b0, 1'b1, 2'd2, 24'd0);       // BOUNCE every cycle
        repeat (6)  drive(1'b0, 1'b1, 2'd3, 24'd1);       // FILL into 07
        repeat (8)  drive(1'b0, 1'b1, 2'd1, 24'd1);       // switch to ROT_R
        repeat (3)  drive(1'b0, 1'b1, 2'd1, 24'd5);
        repeat (10) drive(1'b0, 1'b0, 2'd1, 24'd5);       // frozen
        repeat (6)  drive(1'b0, 1'b1, 2'd1, 24'd1);
        drive(1'b1, 1'b1, 2'd1, 24'd1);                   // mid-pattern reset
        repeat (8)  drive(1'b0, 1'b1, 2'd1, 24'd1);
        repeat (7)  drive(1'b0, 1'b1, 2'd1, 24'd9);
        repeat (4)  drive(1'b0, 1'b1, 2'd1, 24'd2);       // lower below cnt

        rm = 2'd0;
        rd = 24'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) rd = 24'($urandom_range(0, 6));
            re = ($urandom_range(0, 7) != 0);
            drive(($urandom_range(0, 149) == 0), re, rm, rd);
        end

        @(negedge clk);
        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
